spi_read_arbiter: RTL and testbench
===================================

Name: spi_read_arbiter

Overview:
- Shares the single SPI flash byte-read engine between NUM_REQ sample-voice requesters.
- Requesters are the per-trigger fetch channels. Each requester asks for one byte at a 24-bit flash address.
- Grants are round-robin. For each grant, the block drives the SPI engine's start/address pair, waits for data_ready, then returns the byte to the granted requester.
- A watchdog aborts a transaction if the SPI engine stalls, so a stalled read cannot lock up the other voices.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 24, flash address width.
- TIMEOUT_CYCLES, 1024, maximum clk cycles spent in WAIT before abort (must be >=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; bit i is held high until rsp_valid[i].
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- rsp_valid  output  NUM_REQ  one-cycle pulse to the served requester.
- rsp_data  output  8  returned byte; valid while any rsp_valid bit is high.
- rsp_error  output  1  high with rsp_valid when the transaction timed out; rsp_data is then 8'h00.
- busy  output  1  high in any state other than IDLE.
- spi_start_read  output  1  one-cycle start pulse to the SPI engine.
- spi_addr  output  ADDR_W  read address to the SPI engine.
- spi_data_ready  input  1  SPI engine byte-valid pulse.
- spi_data  input  8  SPI engine byte.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0. last_grant=NUM_REQ-1, so requester 0 wins first. Timer=0. Latched id/addr/data are 0. A reset in any state abandons the transaction with no rsp_valid.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, grant the first set bit searching from last_grant+1 upward with wrap-around.
  - Latch grant id and its req_addr slice into the spi_addr register, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: spi_start_read=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT:
  - If spi_data_ready=1, latch spi_data and go to RESP with err=0.
  - Otherwise, if timer==TIMEOUT_CYCLES-1, go to RESP with err=1 and data=0.
  - Otherwise timer+1.
  - spi_data_ready takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid[id]=1, rsp_data and rsp_error driven for exactly one cycle.
  - last_grant=id; go to IDLE.
- Registered outputs: spi_addr is stable from the ISSUE cycle until the next grant; it is not cleared on return to IDLE.
- spi_data_ready pulses in IDLE, ISSUE or RESP are ignored.
- Requester contract:
  - Keep req[i] and its address stable until rsp_valid[i].
  - Drop req[i] on the following edge, or hold it high to request again.
  - If req[i] is dropped mid-transaction, the transaction still completes and rsp_valid[i] still pulses.
  - Address changes after the IDLE grant cycle have no effect.
- Throughput and latency:
  - Minimum 4 cycles per transaction: grant(IDLE) to ISSUE to WAIT to RESP.
  - Latency from req rising in IDLE to rsp_valid is 3 + (cycles waiting in WAIT).
- Fairness: with all requesters held high continuously, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 transactions.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset, then req=4'b0001 with addr0=24'h000100; engine returns 8'hA5 three cycles after start -> one spi_start_read, spi_addr=24'h000100, rsp_valid=4'b0001 with rsp_data=8'hA5 and rsp_error=0; transaction takes 6 cycles.
- req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each spi_addr matches the granted slice.
- req=4'b0100, engine never asserts data_ready, TIMEOUT_CYCLES=16 -> rsp_valid=4'b0100 with rsp_error=1 and rsp_data=8'h00, exactly 16 cycles after the WAIT entry; next request is served normally.
- data_ready asserted on the exact cycle timer reaches TIMEOUT_CYCLES-1 -> rsp_error=0 and the byte is returned.
- reset asserted during WAIT for requester 2 -> no rsp_valid; outputs 0 on the next cycle; a following req=4'b0110 grants 1 first.
- Requester 3 drops req during WAIT, stray data_ready pulse while IDLE -> rsp_valid[3] still pulses once; the stray pulse causes no response or state change.

Source files
------------

// File: rtl/spi_read_arbiter.sv
// Round-robin arbiter that shares one SPI flash byte-read engine between
// NUM_REQ fetch channels, with a watchdog that aborts stalled reads.
module spi_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [7:0]                rsp_data,
  output logic                      rsp_error,
  output logic                      busy,
  output logic                      spi_start_read,
  output logic [ADDR_W-1:0]         spi_addr,
  input  logic                      spi_data_ready,
  input  logic [7:0]                spi_data
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  int unsigned       idx;

  // Round-robin pick: first requesting bit after last_grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant_q) + off) % NUM_REQ;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Next-state logic for the transaction sequencer and its latched fields.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    id_d         = id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          id_d    = grant_id;
          addr_d  = req_addr[grant_id*ADDR_W +: ADDR_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A byte arriving on the final watchdog cycle still wins.
        if (spi_data_ready) begin
          data_d  = spi_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        last_grant_d = id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_ID_RST;
      timer_q      <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  // Outputs decoded from state; response fields are zero outside RESP.
  always_comb begin
    rsp_valid      = '0;
    rsp_data       = '0;
    rsp_error      = 1'b0;
    busy           = (state_q != IDLE);
    spi_start_read = (state_q == ISSUE);
    spi_addr       = addr_q;
    if (state_q == RESP) begin
      rsp_valid[id_q] = 1'b1;
      rsp_data        = data_q;
      rsp_error       = err_q;
    end
  end

endmodule

// File: tb/tb_spi_read_arbiter.sv
// Directed self-checking bench for spi_read_arbiter (4 requesters, 16-cycle watchdog).
module tb_spi_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 24;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [7:0]                rsp_data;
  logic                      rsp_error;
  logic                      busy;
  logic                      spi_start_read;
  logic [ADDR_W-1:0]         spi_addr;
  logic                      spi_data_ready;
  logic [7:0]                spi_data;

  logic [ADDR_W-1:0] addr_tab [NUM_REQ];

  int n_checks = 0;
  int n_pass   = 0;

  spi_read_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .busy           (busy),
    .spi_start_read (spi_start_read),
    .spi_addr       (spi_addr),
    .spi_data_ready (spi_data_ready),
    .spi_data       (spi_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Zero-output check used after reset.
  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_data"},  32'(rsp_data), 0);
    check({tag, "_rsp_error"}, 32'(rsp_error), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_start"},     32'(spi_start_read), 0);
  endtask

  // Called on the negedge of the IDLE grant cycle with req already set.
  // Returns on the negedge of the RESP cycle. n_wait = WAIT cycle (1-based)
  // carrying data_ready; 0 means the engine never answers.
  task automatic txn(input string tag, input int exp_id, input int n_wait,
                     input logic [7:0] byte_v, input bit exp_err,
                     input int exp_len, input bit drop);
    int len;
    int starts;
    int w;
    bit got;
    len = 1; starts = 0; got = 0; w = 0;
    while (!spi_start_read && w < 20) begin
      @(negedge clk);
      len++; w++;
    end
    check({tag, "_start"}, 32'(spi_start_read), 1);
    if (spi_start_read) starts++;
    check({tag, "_addr"}, 32'(spi_addr), 32'(addr_tab[exp_id]));
    check({tag, "_busy"}, 32'(busy), 1);
    w = 0;
    while (!got && w < 100) begin
      @(negedge clk);
      len++;
      if (spi_start_read) starts++;
      if (rsp_valid != '0) begin
        got = 1;
        spi_data_ready = 1'b0;
      end else begin
        w++;
        if (drop && w == 1) req[exp_id] = 1'b0;
        spi_data_ready = (w == n_wait);
        spi_data       = (w == n_wait) ? byte_v : 8'h5A;
      end
    end
    check({tag, "_got_rsp"}, 32'(got), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << exp_id);
    check({tag, "_rsp_data"}, 32'(rsp_data), exp_err ? 32'h0 : 32'(byte_v));
    check({tag, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
    check({tag, "_len"}, 32'(len), 32'(exp_len));
    check({tag, "_one_start"}, 32'(starts), 1);
    check({tag, "_addr_hold"}, 32'(spi_addr), 32'(addr_tab[exp_id]));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    addr_tab[0] = 24'h000100;
    addr_tab[1] = 24'h01A2B3;
    addr_tab[2] = 24'h2C4D5E;
    addr_tab[3] = 24'hFFFFF0;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    reset = 1'b1;
    req = '0;
    spi_data_ready = 1'b0;
    spi_data = 8'h00;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_spi_addr", 32'(spi_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read, byte on the third WAIT cycle: 6-cycle transaction.
    req = 4'b0001;
    txn("single", 0, 3, 8'hA5, 1'b0, 6, 1'b0);
    req = '0;
    @(negedge clk);

    // Re-reset so requester 0 wins first, then rotate with all requesting.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("rr%0d", i), i % 4, (i % 3) + 1, 8'(8'h10 + i), 1'b0, (i % 3) + 4, 1'b0);
      if (i == 7) req = '0;
      @(negedge clk);
    end

    // Engine never answers: abort after 16 WAIT cycles, then a normal read.
    req = 4'b0100;
    txn("timeout", 2, 0, 8'h00, 1'b1, 19, 1'b0);
    @(negedge clk);
    txn("after_tmo", 2, 2, 8'h3C, 1'b0, 5, 1'b0);
    req = '0;
    @(negedge clk);

    // Byte arrives on the final watchdog cycle: data wins over timeout.
    req = 4'b0100;
    txn("edge", 2, 16, 8'hE7, 1'b0, 19, 1'b0);
    req = '0;
    @(negedge clk);

    // Reset while requester 2 is in WAIT.
    req = 4'b0100;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("mid_rst");
    check("mid_rst_spi_addr", 32'(spi_addr), 0);
    reset = 1'b0;
    req = 4'b0110;
    txn("post_rst1", 1, 1, 8'h11, 1'b0, 4, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    txn("post_rst2", 2, 1, 8'h22, 1'b0, 4, 1'b0);
    req = '0;
    @(negedge clk);

    // Requester 3 drops req mid-transaction; stray data_ready while IDLE.
    req = 4'b1000;
    txn("drop", 3, 2, 8'hC3, 1'b0, 5, 1'b1);
    @(negedge clk);
    check("drop_once", 32'(rsp_valid), 0);
    spi_data_ready = 1'b1;
    spi_data = 8'hFF;
    @(negedge clk);
    spi_data_ready = 1'b0;
    check("stray_rsp", 32'(rsp_valid), 0);
    check("stray_busy", 32'(busy), 0);
    check("stray_start", 32'(spi_start_read), 0);
    @(negedge clk);
    check("stray_rsp2", 32'(rsp_valid), 0);
    check("stray_busy2", 32'(busy), 0);
    req = 4'b0001;
    txn("after_stray", 0, 1, 8'h77, 1'b0, 4, 1'b0);
    req = '0;
    @(negedge clk);
    check("final_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
